// File: rtl/amba_apb_param_slave.sv
// APB4 completer backed by a word memory: byte-lane strobed writes, a fixed
// number of wait states per access phase, and PSLVERR on range or strobe errors.
module amba_apb_param_slave #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  pclk,
   input  logic                  prst_n,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pWRITE,
   input  logic [ADDR_W-1:0]     pADDr,
   input  logic [DATA_W-1:0]     pWDATA,
   input  logic [DATA_W/8-1:0]   pSTRB,
   output logic                  pREADY,
   output logic [DATA_W-1:0]     pRDATA,
   output logic                  pSLVERR
);
   localparam int STRB_W = DATA_W/8;

   typedef enum logic {IDLE, ACCESS} state_t;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addrQ;
   logic              wrQ;
   logic              errQ;
   logic [DATA_W-1:0] rdataQ;

   logic setup;
   logic setupErr;
   logic memWe;

   assign setup = psel & ~penable;
   // Extra MSB keeps the compare correct when DEPTH == 2**ADDR_W.
   assign setupErr = ({1'b0, pADDr} >= (ADDR_W+1)'(DEPTH)) | (~pWRITE & (|pSTRB));

   assign pREADY  = (state == ACCESS) && (cnt == 4'd0);
   assign pSLVERR = pREADY & errQ;
   assign pRDATA  = rdataQ;

   assign memWe = pREADY & psel & penable & wrQ & ~errQ;

   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         addrQ  <= '0;
         wrQ    <= 1'b0;
         errQ   <= 1'b0;
         rdataQ <= '0;
      end else begin
         // A setup in either state restarts the transfer; stale ACCESS is dropped.
         if (setup) begin
            state <= ACCESS;
            addrQ <= pADDr;
            wrQ   <= pWRITE;
            cnt   <= 4'(WAIT_CYCLES);
            errQ  <= setupErr;
            if (!pWRITE)
               rdataQ <= setupErr ? '0 : mem[pADDr];
         end else if (state == ACCESS) begin
            if (!psel)
               state <= IDLE;
            else if (cnt != 4'd0)
               cnt <= cnt - 4'd1;
            else
               state <= IDLE;
         end
      end
   end

   // Write data and strobes are taken at the completion edge, not at setup.
   always_ff @(posedge pclk) begin
      if (memWe)
         for (int i = 0; i < STRB_W; i++)
            if (pSTRB[i])
               mem[addrQ][8*i +: 8] <= pWDATA[8*i +: 8];
   end

endmodule

// File: tb/tb_amba_apb_param_slave.sv
// Directed bench for amba_apb_param_slave: driver pushes expected responses,
// a negedge monitor pops and compares whenever pREADY is high.
module tb_amba_apb_param_slave;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 200;
   localparam int WAITC  = 2;

   typedef struct packed {
      logic        isRead;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        pclk = 1'b0;
   logic        prst_n;
   logic        psel, penable, pWRITE;
   logic [7:0]  pADDr;
   logic [31:0] pWDATA;
   logic [3:0]  pSTRB;
   logic        pREADY, pSLVERR;
   logic [31:0] pRDATA;

   int   nChecks = 0;
   int   nFail   = 0;
   int   cyc     = 0;
   exp_t sb[$];

   amba_apb_param_slave #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)
   ) dut (
      .pclk(pclk), .prst_n(prst_n), .psel(psel), .penable(penable),
      .pWRITE(pWRITE), .pADDr(pADDr), .pWDATA(pWDATA), .pSTRB(pSTRB),
      .pREADY(pREADY), .pRDATA(pRDATA), .pSLVERR(pSLVERR)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc++;

   // Monitor: every completed transfer must match the oldest expectation.
   always @(negedge pclk) begin
      exp_t e;
      if (prst_n && pREADY) begin
         nChecks++;
         if (sb.size() == 0) begin
            nFail++;
            $display("FAIL unexpected_ready: pREADY=1 at cycle %0d, required no transfer pending", cyc);
         end else begin
            e = sb.pop_front();
            if (pSLVERR !== e.err) begin
               nFail++;
               $display("FAIL slverr: got %b, required %b (cycle %0d)", pSLVERR, e.err, cyc);
            end
            if (e.isRead) begin
               nChecks++;
               if (pRDATA !== e.data) begin
                  nFail++;
                  $display("FAIL rdata: got %h, required %h (cycle %0d)", pRDATA, e.data, cyc);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      nChecks++;
      if (got !== req) begin
         nFail++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic idle(input int n);
      psel = 1'b0; penable = 1'b0;
      repeat (n) @(posedge pclk);
      #1;
   endtask

   // Full transfer; leaves the bus in access state so another call may follow back-to-back.
   task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] expD, input logic expE);
      int waits;
      exp_t e;
      psel = 1'b1; penable = 1'b0; pWRITE = wr; pADDr = a; pWDATA = d; pSTRB = s;
      e.isRead = ~wr; e.data = expD; e.err = expE;
      sb.push_back(e);
      @(posedge pclk); #1;
      penable = 1'b1;
      waits = 0;
      forever begin
         @(negedge pclk);
         if (pREADY) break;
         waits++;
         if (waits > 40) break;
      end
      check("wait_states", 32'(waits), 32'(WAITC));
      @(posedge pclk); #1;
   endtask

   initial begin
      int t0;
      prst_n = 1'b0; psel = 1'b0; penable = 1'b0; pWRITE = 1'b0;
      pADDr = '0; pWDATA = '0; pSTRB = '0;
      repeat (2) @(negedge pclk);
      check("reset_pready", 32'(pREADY), 32'd0);
      check("reset_pslverr", 32'(pSLVERR), 32'd0);
      check("reset_prdata", pRDATA, 32'd0);
      prst_n = 1'b1;
      @(posedge pclk); #1;

      // penable without a setup phase is ignored
      psel = 1'b1; penable = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         check("no_setup_ready", 32'(pREADY), 32'd0);
      end
      idle(1);

      // byte-lane strobes assemble one word
      xfer(1'b1, 8'd150, 32'h0000_0000, 4'hF, '0, 1'b0);
      xfer(1'b1, 8'd150, 32'h0000_00EF, 4'h1, '0, 1'b0);
      xfer(1'b1, 8'd150, 32'h0000_BE00, 4'h2, '0, 1'b0);
      xfer(1'b1, 8'd150, 32'hACDF_0000, 4'hC, '0, 1'b0);
      xfer(1'b0, 8'd150, '0, 4'h0, 32'hACDF_BEEF, 1'b0);
      idle(1);

      // wait states, last valid word, range errors
      xfer(1'b1, 8'd5,   32'h1111_2222, 4'hF, '0, 1'b0);
      xfer(1'b0, 8'd5,   '0, 4'h0, 32'h1111_2222, 1'b0);
      xfer(1'b1, 8'd199, 32'hCAFE_F00D, 4'hF, '0, 1'b0);
      xfer(1'b0, 8'd199, '0, 4'h0, 32'hCAFE_F00D, 1'b0);
      xfer(1'b1, 8'd220, 32'h1234_5678, 4'hF, '0, 1'b1);
      xfer(1'b0, 8'd220, '0, 4'h0, 32'h0, 1'b1);
      xfer(1'b0, 8'd199, '0, 4'h0, 32'hCAFE_F00D, 1'b0);
      xfer(1'b1, 8'd200, 32'hFFFF_FFFF, 4'hF, '0, 1'b1);
      xfer(1'b0, 8'd200, '0, 4'h0, 32'h0, 1'b1);
      // a read with strobes set is a protocol error and returns zero
      xfer(1'b0, 8'd199, '0, 4'h0, 32'hCAFE_F00D, 1'b0);
      xfer(1'b0, 8'd150, '0, 4'h1, 32'h0, 1'b1);
      xfer(1'b0, 8'd150, '0, 4'h0, 32'hACDF_BEEF, 1'b0);
      idle(1);

      // psel dropped in the wait phase: no write and no pREADY
      psel = 1'b1; penable = 1'b0; pWRITE = 1'b1; pADDr = 8'd5; pWDATA = 32'hFFFF_FFFF; pSTRB = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      check("abort_ready", 32'(pREADY), 32'd0);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      repeat (3) begin
         @(negedge pclk);
         check("abort_idle_ready", 32'(pREADY), 32'd0);
      end
      @(posedge pclk); #1;
      xfer(1'b0, 8'd5, '0, 4'h0, 32'h1111_2222, 1'b0);

      // reset in the middle of a write's wait phase
      psel = 1'b1; penable = 1'b0; pWRITE = 1'b1; pADDr = 8'd5; pWDATA = 32'hDEAD_BEEF; pSTRB = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      prst_n = 1'b0;
      #1;
      check("midreset_pready", 32'(pREADY), 32'd0);
      check("midreset_pslverr", 32'(pSLVERR), 32'd0);
      check("midreset_prdata", pRDATA, 32'd0);
      psel = 1'b0; penable = 1'b0;
      repeat (2) @(negedge pclk);
      prst_n = 1'b1;
      @(posedge pclk); #1;
      xfer(1'b0, 8'd5, '0, 4'h0, 32'h1111_2222, 1'b0);

      // back-to-back write/read pairs with no idle cycles
      t0 = cyc;
      for (int i = 0; i < 16; i++) begin
         xfer(1'b1, 8'(i), 32'h5A00_0000 + 32'(i) * 32'h0001_0203, 4'hF, '0, 1'b0);
         xfer(1'b0, 8'(i), '0, 4'h0, 32'h5A00_0000 + 32'(i) * 32'h0001_0203, 1'b0);
      end
      check("throughput_cycles", 32'(cyc - t0), 32'(32 * (WAITC + 2)));
      idle(2);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
